// File: rtl/coreuart_pkg.sv
// Shared CoreUART types: auto-baud FSM states and error codes.
package coreuart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    CALC
  } ab_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_FAST    = 2'b10;
  localparam logic [1:0] ERR_JITTER  = 2'b11;

endpackage

// File: rtl/coreuart_rx_sync.sv
// Two-flop RX synchronizer plus registered falling-edge detector.
module coreuart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = rx;
    s2_d   = s1_q;
    prev_d = s2_q;
    fall_d = prev_q & ~s2_q;
  end

  // Line idles high, so flops come out of reset as 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/coreuart_autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync character and
// loads the integer/fractional baud divisor.
module coreuart_autobaud_ctrl
  import coreuart_pkg::*;
#(
  parameter int          CNT_W           = 21,
  parameter logic [12:0] RESET_BAUD_VAL  = 13'd1,
  parameter logic [2:0]  RESET_BAUD_FRAC = 3'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        RX,
  input  logic        SW_LOAD,
  input  logic [12:0] SW_BAUD_VAL,
  input  logic [2:0]  SW_BAUD_FRAC,
  output logic [12:0] BAUD_VAL,
  output logic [2:0]  BAUD_VAL_FRACTION,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic fall;

  coreuart_rx_sync u_sync (
    .clk   (CLK),
    .reset (RESET),
    .rx    (RX),
    .fall  (fall)
  );

  ab_state_e        state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] iv_q, iv_d;
  logic [CNT_W-1:0] i1_q, i1_d;
  logic [2:0]       k_q, k_d;
  logic [12:0]      baud_q, baud_d;
  logic [2:0]       frac_q, frac_d;
  logic [1:0]       code_q, code_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] ik, diff;
  logic             jit;
  logic [15:0]      q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    iv_d    = iv_q;
    i1_d    = i1_q;
    k_d     = k_q;
    baud_d  = baud_q;
    frac_d  = frac_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    ik   = iv_q + ONE;
    diff = (ik > i1_q) ? ik - i1_q : i1_q - ik;
    jit  = diff > (i1_q >> 2);
    q    = 16'((32'(n_q) + 32'd8) >> 4);

    unique case (state_q)
      IDLE: ;
      ARM: begin
        n_d  = '0;
        iv_d = '0;
        k_d  = '0;
        if (fall) state_d = MEAS;
      end
      MEAS: begin
        n_d  = n_q + ONE;
        iv_d = iv_q + ONE;
        if (fall) begin
          k_d  = k_q + 3'd1;
          iv_d = '0;
          if (k_q == 3'd0) begin
            i1_d = ik;
          end else if (jit) begin
            err_d   = 1'b1;
            code_d  = ERR_JITTER;
            state_d = IDLE;
          end else if (k_q == 3'd3) begin
            state_d = CALC;
          end
        end
        if (state_d == MEAS && (&n_q)) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      CALC: begin
        state_d = IDLE;
        if (q < 16'd8) begin
          err_d  = 1'b1;
          code_d = ERR_FAST;
        end else begin
          baud_d = q[15:3] - 13'd1;
          frac_d = q[2:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (START) begin
      state_d = ARM;
      code_d  = ERR_NONE;
      n_d     = '0;
      iv_d    = '0;
      k_d     = '0;
      baud_d  = baud_q;
      frac_d  = frac_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Software load overrides everything, including a same-cycle CALC.
    if (SW_LOAD) begin
      state_d = IDLE;
      baud_d  = SW_BAUD_VAL;
      frac_d  = SW_BAUD_FRAC;
      code_d  = code_q;
      done_d  = 1'b1;
      err_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      n_q     <= '0;
      iv_q    <= '0;
      i1_q    <= '0;
      k_q     <= '0;
      baud_q  <= RESET_BAUD_VAL;
      frac_q  <= RESET_BAUD_FRAC;
      code_q  <= ERR_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      iv_q    <= iv_d;
      i1_q    <= i1_d;
      k_q     <= k_d;
      baud_q  <= baud_d;
      frac_q  <= frac_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BAUD_VAL          = baud_q;
  assign BAUD_VAL_FRACTION = frac_q;
  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERR               = err_q;
  assign ERR_CODE          = code_q;

endmodule
